// File: rtl/zt_stl_pkg.sv
// Shared helpers for the zt_stl delay-line primitives.
package zt_stl_pkg;

    localparam int ZT_STL_MINW = 1;

    function automatic int ZT_STL_CLOG2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/zt_stl_shift_stage.sv
// One {valid, data} stage of the programmable delay line.
module zt_stl_shift_stage #(
    parameter int WIDTH    = 8,
    parameter int GATEDATA = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             flush,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_q,
    output logic [WIDTH-1:0] d_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            if (flush)    v_q <= 1'b0;
            else if (adv) v_q <= v_in;
            // Data may shift during a flush; its valid is cleared so the value is unobservable as a beat.
            if (adv && (GATEDATA == 0 || v_in)) d_q <= d_in;
        end
    end

endmodule

// File: rtl/zt_stl_shift_pipe.sv
// Multi-channel delay line with per-cycle selectable tap, stall and flush.
module zt_stl_shift_pipe
    import zt_stl_pkg::*;
#(
    parameter int BITDATA  = 8,
    parameter int NUMCHAN  = 1,
    parameter int MAXDELAY = 4,
    parameter int GATEDATA = 0,
    parameter int DLYW     = (ZT_STL_CLOG2(MAXDELAY + 1) < ZT_STL_MINW) ? ZT_STL_MINW
                                                                         : ZT_STL_CLOG2(MAXDELAY + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       adv,
    input  logic                       flush,
    input  logic [DLYW-1:0]            dly,
    input  logic                       vld_in,
    input  logic [NUMCHAN*BITDATA-1:0] din,
    output logic                       vld_out,
    output logic [NUMCHAN*BITDATA-1:0] dout,
    output logic                       busy,
    output logic                       dly_err
);

    localparam int              W    = NUMCHAN * BITDATA;
    localparam logic [DLYW-1:0] MAXD = DLYW'(MAXDELAY);

    // Index 0 is the combinational input stage; 1..MAXDELAY are registers.
    logic [MAXDELAY:0]        vld;
    logic [MAXDELAY:0][W-1:0] dat;
    logic [DLYW-1:0]          tap;

    assign vld[0] = vld_in;
    assign dat[0] = din;

    for (genvar k = 1; k <= MAXDELAY; k++) begin : g_stage
        zt_stl_shift_stage #(
            .WIDTH    (W),
            .GATEDATA (GATEDATA)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .adv   (adv),
            .flush (flush),
            .v_in  (vld[k-1]),
            .d_in  (dat[k-1]),
            .v_q   (vld[k]),
            .d_q   (dat[k])
        );
    end

    assign dly_err = (dly > MAXD);
    assign busy    = |vld[MAXDELAY:1];

    always_comb begin
        tap     = dly_err ? MAXD : dly;
        vld_out = vld[tap];
        dout    = dat[tap];
    end

endmodule

// File: tb/tb_zt_stl_shift_pipe.sv
// Directed bench for zt_stl_shift_pipe with a beat-history reference model.
module tb_zt_stl_shift_pipe;

    localparam int BD = 8, NC = 3, MD = 4, DW = 3, W = BD * NC;

    logic         clk = 1'b0;
    logic         rst, adv, flush, vld_in;
    logic [DW-1:0] dly;
    logic [W-1:0] din;
    logic         vld_out, busy, dly_err;
    logic [W-1:0] dout;

    int n_tests = 0;
    int n_fail  = 0;

    zt_stl_shift_pipe #(
        .BITDATA (BD),
        .NUMCHAN (NC),
        .MAXDELAY(MD),
        .GATEDATA(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .adv     (adv),
        .flush   (flush),
        .dly     (dly),
        .vld_in  (vld_in),
        .din     (din),
        .vld_out (vld_out),
        .dout    (dout),
        .busy    (busy),
        .dly_err (dly_err)
    );

    always #5 clk = ~clk;

    // Model: history of beats accepted on advances, newest first; entry i is what sits at delay i+1.
    typedef struct { bit v; logic [W-1:0] d; } beat_t;
    beat_t hist[$];
    bit    fresh;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            for (int i = 0; i < MD; i++) hist.push_back('{1'b0, '0});
            fresh = 1'b1;
        end else if (flush) begin
            foreach (hist[i]) hist[i].v = 1'b0;
            if (adv) begin
                hist.push_front('{1'b0, '0});
                void'(hist.pop_back());
                fresh = 1'b0;
            end
        end else if (adv) begin
            hist.push_front('{vld_in, din});
            void'(hist.pop_back());
            fresh = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        int    e;
        bit    ev, eb;
        logic [W-1:0] ed;
        e  = (int'(dly) > MD) ? MD : int'(dly);
        eb = 1'b0;
        foreach (hist[i]) eb |= hist[i].v;
        if (e == 0) begin ev = vld_in; ed = din; end
        else begin ev = hist[e-1].v; ed = hist[e-1].d; end
        chk("model_vld_out", W'(vld_out), W'(ev));
        chk("model_busy",    W'(busy),    W'(eb));
        chk("model_dly_err", W'(dly_err), W'(int'(dly) > MD));
        if (ev || e == 0 || fresh) chk("model_dout", dout, ed);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        adv = 1'b0; flush = 1'b0; vld_in = 1'b0; din = '0;
    endtask

    int cnt;

    initial begin
        rst = 1'b1; dly = 3'd2; idle();
        step(); step();
        chk("reset_busy", W'(busy), '0);
        chk("reset_vld_out", W'(vld_out), '0);
        chk("reset_dout", dout, '0);
        rst = 1'b0;
        step();

        // 1: async reset with four valid beats in flight
        adv = 1'b1; vld_in = 1'b1;
        for (int i = 0; i < 4; i++) begin din = W'(32'h10 + i); step(); end
        idle();
        @(negedge clk);
        chk("t1_busy_before", W'(busy), W'(1));
        #2 rst = 1'b1; #1;
        chk("t1_busy", W'(busy), '0);
        chk("t1_vld_out", W'(vld_out), '0);
        chk("t1_dout", dout, '0);
        step(); rst = 1'b0; step();

        // 2: latency dly=3
        dly = 3'd3; adv = 1'b1; vld_in = 1'b1; din = 24'h0000A5;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t2_vld_c%0d", i), W'(vld_out), W'(i == 3));
            if (i == 3) chk("t2_dout", dout, 24'h0000A5);
            step(); vld_in = 1'b0; din = '0;
        end

        // 3: two stall cycles push the beat to t0+5
        cnt = 0;
        vld_in = 1'b1; din = 24'h0000A5; adv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cnt += int'(vld_out);
            chk($sformatf("t3_vld_c%0d", i), W'(vld_out), W'(i == 5));
            step(); vld_in = 1'b0; din = '0;
            adv = !(i == 0 || i == 1);
        end
        chk("t3_count", W'(cnt), W'(1));

        // 4: flush with adv=0 and a concurrent input beat
        dly = 3'd4; adv = 1'b1; vld_in = 1'b1;
        for (int i = 0; i < 4; i++) begin din = W'(32'h40 + i); step(); end
        chk("t4_busy_before", W'(busy), W'(1));
        flush = 1'b1; adv = 1'b0; vld_in = 1'b1; din = 24'hBEEF00;
        step();
        idle();
        chk("t4_busy_after", W'(busy), '0);
        adv = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); cnt += int'(vld_out); step(); end
        chk("t4_no_beat", W'(cnt), '0);

        // 5: passthrough and clamp
        idle(); dly = 3'd0; vld_in = 1'b1; din = 24'h123456; #1;
        chk("t5_pass_dout", dout, 24'h123456);
        chk("t5_pass_vld", W'(vld_out), W'(1));
        dly = 3'd4; adv = 1'b1;
        for (int i = 0; i < 4; i++) begin din = W'(32'h010101 * (i + 1)); step(); end
        idle(); #1;
        chk("t5_tap4_dout", dout, 24'h010101);
        dly = 3'd7; #1;
        chk("t5_clamp_err", W'(dly_err), W'(1));
        chk("t5_clamp_dout", dout, 24'h010101);
        chk("t5_clamp_vld", W'(vld_out), W'(1));
        dly = 3'd4; #1;
        chk("t5_err_clear", W'(dly_err), '0);

        // 6: gated data holds through an invalid beat
        flush = 1'b1; step(); flush = 1'b0;
        dly = 3'd1; adv = 1'b1; vld_in = 1'b1; din = 24'h112233;
        step();
        vld_in = 1'b0; din = 24'hFFFFFF;
        @(negedge clk);
        chk("t6_vld_first", W'(vld_out), W'(1));
        chk("t6_dout_first", dout, 24'h112233);
        step();
        @(negedge clk);
        chk("t6_vld_second", W'(vld_out), '0);
        chk("t6_gated_hold", dout, 24'h112233);
        step(); idle(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
